// File: rtl/wb_trace_if.sv
// wb_trace_if: writeback tap from the CPU plus the serialised trace stream.
// master = CPU/consumer side, slave = the trace encoder.
interface wb_trace_if #(parameter int DEPTH = 16);
    logic                     trace_en;
    logic                     reg_write_enable;
    logic [4:0]               reg_write_addr;
    logic [31:0]              reg_write_data;
    logic                     hilo_we;
    logic [31:0]              hi_i;
    logic [31:0]              lo_i;
    logic [31:0]              trace_data;
    logic                     trace_valid;
    logic                     trace_ready;
    logic                     overflow;
    logic [15:0]              drop_count;
    logic [$clog2(DEPTH):0]   fifo_level;
    modport master (
        output trace_en, reg_write_enable, reg_write_addr, reg_write_data,
               hilo_we, hi_i, lo_i, trace_ready,
        input  trace_data, trace_valid, overflow, drop_count, fifo_level
    );
    modport slave (
        input  trace_en, reg_write_enable, reg_write_addr, reg_write_data,
               hilo_we, hi_i, lo_i, trace_ready,
        output trace_data, trace_valid, overflow, drop_count, fifo_level
    );
endinterface

// File: rtl/wb_trace_encoder.sv
// wb_trace_encoder: records numbered writeback events into a FIFO and
// serialises them as a 32-bit valid/ready word stream.
module wb_trace_encoder #(
    parameter int DEPTH     = 16,
    parameter int WARMUP    = 5,
    parameter int EMIT_SKIP = 1
) (
    input logic       clk,
    input logic       rst,
    wb_trace_if.slave tr
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    typedef enum logic [1:0] {IDLE, HDR, W1, W2} state_t;
    state_t        state_q;
    logic [WW-1:0] warm_q;
    logic [24:0]   seq_q, seq_d;
    logic [95:0]   mem_q [DEPTH];
    logic [65:0]   hold_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [31:0]   data_q;
    logic          valid_q, ovf_q;
    logic [15:0]   drop_q;
    logic          rec, is_reg, is_hilo, want, push, drop, avail, done, pop;
    logic [1:0]    typ;
    logic [95:0]   rec_w;
    always_comb begin
        rec     = tr.trace_en && warm_q == WW'(WARMUP);
        seq_d   = rec ? seq_q + 25'd1 : seq_q;
        is_reg  = tr.reg_write_enable;
        is_hilo = !is_reg && tr.hilo_we;
        typ     = is_reg ? 2'b01 : is_hilo ? 2'b10 : 2'b00;
        rec_w   = {typ, is_reg ? tr.reg_write_addr : 5'd0, seq_d,
                   is_reg ? tr.reg_write_data : tr.hi_i, tr.lo_i};
        want    = rec && (EMIT_SKIP != 0 || is_reg || is_hilo);
        push    = want && cnt_q < (AW+1)'(DEPTH);
        drop    = want && !push;
        // cnt_q also counts the record in flight, so stored entries = cnt_q - busy
        avail   = cnt_q != (AW+1)'(state_q != IDLE);
        done    = valid_q && tr.trace_ready &&
                  ((state_q == HDR && hold_q[65:64] == 2'b00) ||
                   (state_q == W1 && hold_q[65:64] == 2'b01) || state_q == W2);
        pop     = avail && (state_q == IDLE || done);
    end
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= rec_w;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q  <= '0;
            seq_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            state_q <= IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            warm_q <= !tr.trace_en ? '0 : rec ? warm_q : warm_q + WW'(1);
            seq_q  <= !tr.trace_en ? '0 : seq_d;
            wr_q   <= wr_q + AW'(push);
            rd_q   <= rd_q + AW'(pop);
            cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(done);
            ovf_q  <= ovf_q | drop;
            drop_q <= drop_q + 16'(drop && drop_q != 16'hFFFF);
            // a pop from IDLE takes one load cycle; a pop on the last word streams on
            if (pop) begin
                hold_q  <= {mem_q[rd_q][95:94], mem_q[rd_q][63:0]};
                data_q  <= mem_q[rd_q][95:64];
                valid_q <= done;
                state_q <= HDR;
            end else if (done) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end else if (state_q == HDR && !valid_q) begin
                valid_q <= 1'b1;
            end else if (valid_q && tr.trace_ready) begin
                data_q  <= state_q == HDR ? hold_q[63:32] : hold_q[31:0];
                state_q <= state_q == HDR ? W1 : W2;
            end
        end
    end
    assign tr.trace_data  = data_q;
    assign tr.trace_valid = valid_q;
    assign tr.overflow    = ovf_q;
    assign tr.drop_count  = drop_q;
    assign tr.fifo_level  = cnt_q;
endmodule

// File: tb/tb_wb_trace_encoder.sv
// tb_wb_trace_encoder: table vectors, directed corner sequences and random
// stimulus against a queue-based record/word model.
module tb_wb_trace_encoder;
    localparam int DEPTH = 16, WARMUP = 5;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    wb_trace_if #(.DEPTH(DEPTH)) bus ();
    wb_trace_if #(.DEPTH(DEPTH)) bus2 ();
    wb_trace_encoder #(.DEPTH(DEPTH), .WARMUP(WARMUP), .EMIT_SKIP(1)) dut (
        .clk(clk), .rst(rst), .tr(bus.slave));
    wb_trace_encoder #(.DEPTH(DEPTH), .WARMUP(WARMUP), .EMIT_SKIP(0)) dut_ns (
        .clk(clk), .rst(rst), .tr(bus2.slave));
    assign bus2.trace_en         = bus.trace_en;
    assign bus2.reg_write_enable = bus.reg_write_enable;
    assign bus2.reg_write_addr   = bus.reg_write_addr;
    assign bus2.reg_write_data   = bus.reg_write_data;
    assign bus2.hilo_we          = bus.hilo_we;
    assign bus2.hi_i             = bus.hi_i;
    assign bus2.lo_i             = bus.lo_i;
    assign bus2.trace_ready      = 1'b1;

    int checks = 0, errors = 0;
    logic [31:0] log_q[$], log2_q[$];

    typedef struct { int n; logic [31:0] w [3]; } rec_t;
    rec_t        m_fifo[$];
    logic [31:0] m_cur[$];
    bit          m_valid, m_load, m_ovf;
    int          m_warm, m_seq, m_drop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete(); m_cur.delete();
        m_valid = 0; m_load = 0; m_ovf = 0; m_warm = 0; m_seq = 0; m_drop = 0;
    endtask

    task automatic model_load();
        rec_t r = m_fifo.pop_front();
        for (int k = 0; k < r.n; k++) m_cur.push_back(r.w[k]);
    endtask

    // One clock edge of the specification: events numbered and queued, records
    // occupy space until their last word is taken, idle start costs one cycle.
    task automatic model_step(input logic en, input logic rwe, input logic [4:0] a,
                              input logic [31:0] d, input logic hwe,
                              input logic [31:0] hi, input logic [31:0] lo, input logic rdy);
        int lvl = m_fifo.size() + (m_cur.size() > 0 ? 1 : 0);
        rec_t r;
        if (m_valid && rdy) begin
            void'(m_cur.pop_front());
            if (m_cur.size() == 0) begin
                m_valid = 0;
                if (m_fifo.size() > 0) begin model_load(); m_valid = 1; end
            end
        end else if (m_load) begin
            m_valid = 1; m_load = 0;
        end else if (!m_valid && m_cur.size() == 0 && m_fifo.size() > 0) begin
            model_load(); m_load = 1;
        end
        if (!en) begin
            m_warm = 0; m_seq = 0;
        end else if (m_warm < WARMUP) begin
            m_warm++;
        end else begin
            m_seq = (m_seq + 1) % (1 << 25);
            if (rwe) begin
                r.n = 2; r.w[0] = 32'h4000_0000 + (32'(a) << 25) + 32'(m_seq); r.w[1] = d;
            end else if (hwe) begin
                r.n = 3; r.w[0] = 32'h8000_0000 + 32'(m_seq); r.w[1] = hi; r.w[2] = lo;
            end else begin
                r.n = 1; r.w[0] = 32'(m_seq);
            end
            if (lvl < DEPTH) m_fifo.push_back(r);
            else begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
        end
    endtask

    task automatic set_in(logic rwe, logic [4:0] a, logic [31:0] d,
                          logic hwe, logic [31:0] hi, logic [31:0] lo);
        bus.reg_write_enable = rwe; bus.reg_write_addr = a; bus.reg_write_data = d;
        bus.hilo_we = hwe; bus.hi_i = hi; bus.lo_i = lo;
    endtask

    task automatic tick();
        logic en = bus.trace_en, rwe = bus.reg_write_enable, hwe = bus.hilo_we;
        logic rdy = bus.trace_ready;
        logic [4:0] a = bus.reg_write_addr;
        logic [31:0] d = bus.reg_write_data, hi = bus.hi_i, lo = bus.lo_i;
        if (bus.trace_valid && bus.trace_ready) log_q.push_back(bus.trace_data);
        if (bus2.trace_valid) log2_q.push_back(bus2.trace_data);
        @(posedge clk);
        model_step(en, rwe, a, d, hwe, hi, lo, rdy);
        #1;
        chk("valid", 32'(bus.trace_valid), 32'(m_valid));
        if (m_valid) chk("data", bus.trace_data, m_cur[0]);
        chk("level", 32'(bus.fifo_level), m_fifo.size() + (m_cur.size() > 0 ? 1 : 0));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("drop_count", 32'(bus.drop_count), 32'(m_drop));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        bus.trace_en = 0; bus.trace_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        log_q.delete(); log2_q.delete();
    endtask

    typedef struct {
        logic rwe; logic [4:0] a; logic [31:0] d;
        logic hwe; logic [31:0] hi; logic [31:0] lo;
        int seq; int n; logic [31:0] w [3];
    } vec_t;
    vec_t tv [6];

    initial begin
        int idx;
        bit ok;
        tv[0] = '{1'b0, 5'd0, 32'd0, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 7, 3,
                  '{32'h80000007, 32'hAAAA0000, 32'h0000BBBB}};
        tv[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h1, 32'h2, 3, 2,
                  '{32'h7E000003, 32'hFFFFFFFF, 32'h0}};
        tv[2] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 4, 2,
                  '{32'h40000004, 32'hDEADBEEF, 32'h0}};
        tv[3] = '{1'b0, 5'd9, 32'h12345678, 1'b0, 32'h0, 32'h0, 2, 1,
                  '{32'h00000002, 32'h0, 32'h0}};
        tv[4] = '{1'b1, 5'd5, 32'h00000000, 1'b0, 32'h0, 32'h0, 1, 2,
                  '{32'h4A000001, 32'h00000000, 32'h0}};
        tv[5] = '{1'b0, 5'd3, 32'h0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 10, 3,
                  '{32'h8000000A, 32'h00000000, 32'hFFFFFFFF}};

        // reset state
        do_reset();
        chk("rst_valid", 32'(bus.trace_valid), 0);
        chk("rst_data", bus.trace_data, 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_drop", 32'(bus.drop_count), 0);

        // warmup, first sequence number and pop latency
        bus.trace_en = 1; bus.trace_ready = 1;
        repeat (WARMUP) tick();
        set_in(1, 5'd1, 32'h00001234, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        chk("latency_n1_idle", 32'(bus.trace_valid), 0);
        tick();
        chk("latency_n2_valid", 32'(bus.trace_valid), 1);
        chk("latency_n2_hdr", bus.trace_data, 32'h42000001);
        repeat (10) tick();
        chk("warm_w0", log_q[0], 32'h42000001);
        chk("warm_w1", log_q[1], 32'h00001234);
        chk("warm_w2", log_q[2], 32'h00000002);
        chk("warm_w3", log_q[3], 32'h00000003);
        chk("warm_w4", log_q[4], 32'h00000004);

        // single-event vectors
        foreach (tv[t]) begin
            do_reset();
            bus.trace_en = 1; bus.trace_ready = 1;
            repeat (WARMUP + tv[t].seq - 1) tick();
            set_in(tv[t].rwe, tv[t].a, tv[t].d, tv[t].hwe, tv[t].hi, tv[t].lo);
            tick();
            set_in(0, 0, 0, 0, 0, 0);
            repeat (30) tick();
            idx = -1;
            for (int i = 0; i < log_q.size() && idx < 0; i++)
                if (log_q[i] == tv[t].w[0]) idx = i;
            chk($sformatf("vec%0d_found", t), 32'(idx >= 0), 1);
            if (idx >= 0 && idx + tv[t].n < log_q.size()) begin
                for (int k = 1; k < tv[t].n; k++)
                    chk($sformatf("vec%0d_w%0d", t, k), log_q[idx + k], tv[t].w[k]);
                chk($sformatf("vec%0d_next", t), log_q[idx + tv[t].n], 32'(tv[t].seq + 1));
            end
        end

        // backpressure and overflow
        do_reset();
        bus.trace_en = 1; bus.trace_ready = 0;
        repeat (WARMUP + 40) tick();
        chk("bp_level", 32'(bus.fifo_level), 16);
        chk("bp_overflow", 32'(bus.overflow), 1);
        chk("bp_drop", 32'(bus.drop_count), 24);
        bus.trace_en = 0;
        for (int i = 0; i < 80; i++) begin
            bus.trace_ready = ($urandom % 2) == 0;
            tick();
        end
        bus.trace_ready = 1;
        repeat (4) tick();
        chk("bp_count", log_q.size(), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            chk($sformatf("bp_seq%0d", i + 1), log_q[i], 32'(i + 1));

        // EMIT_SKIP=0 instance: skips vanish, seq gaps stay
        do_reset();
        bus.trace_en = 1; bus.trace_ready = 1;
        repeat (WARMUP + 1) tick();
        set_in(1, 5'd1, 32'h00000055, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        set_in(1, 5'd2, 32'h00000099, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        bus.trace_en = 0;
        repeat (12) tick();
        chk("ns_count", log2_q.size(), 4);
        if (log2_q.size() == 4) begin
            chk("ns_w0", log2_q[0], 32'h42000002);
            chk("ns_w1", log2_q[1], 32'h00000055);
            chk("ns_w2", log2_q[2], 32'h44000009);
            chk("ns_w3", log2_q[3], 32'h00000099);
        end
        chk("ns_drop", 32'(bus2.drop_count), 0);
        chk("ns_overflow", 32'(bus2.overflow), 0);

        // asynchronous reset in the middle of a HILO record
        do_reset();
        bus.trace_en = 1; bus.trace_ready = 1;
        repeat (WARMUP) tick();
        set_in(0, 0, 0, 1, 32'h11111111, 32'h22222222);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        bus.trace_en = 0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            ok = bus.trace_valid && bus.trace_data == 32'h11111111;
        end
        chk("ar_reached_hi", 32'(ok), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid_now", 32'(bus.trace_valid), 0);
        chk("ar_level_now", 32'(bus.fifo_level), 0);
        chk("ar_data_now", bus.trace_data, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        log_q.delete();
        repeat (10) tick();
        chk("ar_no_words", log_q.size(), 0);
        chk("ar_level_after", 32'(bus.fifo_level), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.trace_en    = ($urandom % 24) != 0;
            bus.trace_ready = ($urandom % 4) != 0;
            set_in(($urandom % 4) == 0, 5'($urandom), $urandom,
                   ($urandom % 4) == 0, $urandom, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
